chesssoc_led_ctrl: RTL and testbench

Parametrised Avalon-MM LED output controller for the chess SoC, the successor to the fixed 10-bit LED PIO. It keeps the plain write/read data register at address 0, so existing software still works. It adds atomic set/clear/toggle access, per-channel hardware blink and a global PWM brightness control. It sits on the CPU's Avalon-MM bus as a zero-wait-state slave, and its outputs drive the board LEDs directly.

---
 rtl/chesssoc_led_pkg.sv | 27 ++
 rtl/chesssoc_led_ctrl_if.sv | 20 ++
 rtl/chesssoc_led_blink_timer.sv | 61 ++++++
 rtl/chesssoc_led_ctrl.sv | 103 ++++++++++
 tb/tb_chesssoc_led_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/chesssoc_led_pkg.sv
// Shared constants for the chess SoC LED controller: register map and field widths.
// Pure declarations; no timing.
// No flow control involved.
package chesssoc_led_pkg;

  // Word addresses of the register file
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_MODE      = 3'd4;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd5;
  localparam logic [2:0] ADDR_DUTY      = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  // PWM counter runs 0..PWM_MAX, so DUTY=255 means fully on
  localparam logic [7:0] PWM_MAX = 8'd254;

  localparam int BLINK_DIV_W = 16;
  localparam int DUTY_W      = 8;

  // STATUS layout: bit0 blink phase, bits[15:8] PWM counter
  function automatic logic [31:0] status_word(input logic phase, input logic [7:0] pwm_cnt);
    return {16'h0000, pwm_cnt, 7'h00, phase};
  endfunction

endpackage

// File: rtl/chesssoc_led_ctrl_if.sv
// Avalon-MM slave bus of the LED controller (zero wait state, no waitrequest).
// readdata is combinational from address.
// No backpressure: every access completes in one cycle.
interface chesssoc_led_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/chesssoc_led_blink_timer.sv
// Blink timebase: prescaler producing a tick every PRESCALE clocks, and a blink counter toggling phase.
// phase changes on the edge that sees blink_cnt == div during a tick.
// restart clears both counters and takes priority over a coincident tick; phase is kept.
module chesssoc_led_blink_timer
  import chesssoc_led_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BLINK_DIV_W-1:0] div,
  input  logic                   restart,
  output logic                   phase
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic [BLINK_DIV_W-1:0] cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic                   tick;

  assign tick  = (presc_q == PRESC_LAST);
  assign phase = phase_q;

  // Next-state: restart wins over tick so a BLINK_DIV write never toggles phase
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (cnt_q == div) begin
          phase_d = ~phase_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BLINK_DIV_W'(1);
        end
      end
    end
  end

  // State registers; phase starts high so blinking channels start lit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/chesssoc_led_ctrl.sv
// LED output controller: DATA/SET/CLEAR/TOGGLE/MODE registers, hardware blink and global PWM brightness.
// Register writes visible on readdata after the write edge; out_port follows one clock later.
// Zero-wait-state slave, no backpressure.
module chesssoc_led_ctrl
  import chesssoc_led_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
  parameter int               PRESCALE        = 50000,
  parameter int               BLINK_DIV_RESET = 249
) (
  input  logic                clk,
  input  logic                reset_n,
  chesssoc_led_ctrl_if.slave  bus,
  output logic [WIDTH-1:0]    out_port
);

  logic [WIDTH-1:0]       data_q, data_d;
  logic [WIDTH-1:0]       mode_q, mode_d;
  logic [BLINK_DIV_W-1:0] div_q, div_d;
  logic [DUTY_W-1:0]      duty_q, duty_d;
  logic [7:0]             pwm_q, pwm_d;
  logic [WIDTH-1:0]       out_q, out_d;

  logic                   wr;
  logic [WIDTH-1:0]       wd;
  logic                   restart;
  logic                   phase;
  logic                   pwm_on;
  logic                   unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign restart   = wr && (bus.address == ADDR_BLINK_DIV);
  assign unused_wd = ^bus.writedata;
  assign pwm_on    = (pwm_q < duty_q);
  assign out_port  = out_q;

  chesssoc_led_blink_timer #(
    .PRESCALE (PRESCALE)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (div_q),
    .restart (restart),
    .phase   (phase)
  );

  // Register-file writes, free-running PWM counter and output mux
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    div_d  = div_q;
    duty_d = duty_q;
    if (wr) begin
      unique case (bus.address)
        ADDR_DATA:      data_d = wd;
        ADDR_SET:       data_d = data_q | wd;
        ADDR_CLEAR:     data_d = data_q & ~wd;
        ADDR_TOGGLE:    data_d = data_q ^ wd;
        ADDR_MODE:      mode_d = wd;
        ADDR_BLINK_DIV: div_d  = bus.writedata[BLINK_DIV_W-1:0];
        ADDR_DUTY:      duty_d = bus.writedata[DUTY_W-1:0];
        default:        ;
      endcase
    end
    pwm_d = (pwm_q == PWM_MAX) ? 8'd0 : pwm_q + 8'd1;
    out_d = data_q & (~mode_q | {WIDTH{phase}}) & {WIDTH{pwm_on}};
  end

  // Control registers and the LED drive flop; reset mirrors the legacy PIO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mode_q <= '0;
      div_q  <= BLINK_DIV_W'(BLINK_DIV_RESET);
      duty_q <= 8'hFF;
      pwm_q  <= '0;
      out_q  <= RESET_VALUE;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
      div_q  <= div_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      out_q  <= out_d;
    end
  end

  // Zero-latency read mux; write-only strobes and unused bits read 0
  always_comb begin
    bus.readdata = 32'h0;
    unique case (bus.address)
      ADDR_DATA:      bus.readdata = 32'(data_q);
      ADDR_MODE:      bus.readdata = 32'(mode_q);
      ADDR_BLINK_DIV: bus.readdata = 32'(div_q);
      ADDR_DUTY:      bus.readdata = 32'(duty_q);
      ADDR_STATUS:    bus.readdata = status_word(phase, pwm_q);
      default:        bus.readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_chesssoc_led_ctrl.sv
// Bench for chesssoc_led_ctrl: directed register accesses plus a per-cycle reference model.
// Model tracks elapsed clocks since restart/reset and derives phase/PWM arithmetically.
// Inputs driven 2 ns after posedge, outputs sampled on negedge.
module tb_chesssoc_led_ctrl;
  import chesssoc_led_pkg::*;

  localparam int         W  = 10;
  localparam int         P  = 4;
  localparam logic [9:0] RV = 10'h155;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] out_port;

  chesssoc_led_ctrl_if bus();

  chesssoc_led_ctrl #(
    .WIDTH           (W),
    .RESET_VALUE     (RV),
    .PRESCALE        (P),
    .BLINK_DIV_RESET (249)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0]  m_data  = RV;
  logic [9:0]  m_mode  = '0;
  logic [15:0] m_div   = 16'd249;
  logic [7:0]  m_duty  = 8'hFF;
  logic        m_phase = 1'b1;
  logic [9:0]  m_out   = RV;
  int          m_t     = 0;   // clocks since last reset or BLINK_DIV write
  int          m_g     = 0;   // clocks since reset

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_data);
      3'd4:    return 32'(m_mode);
      3'd5:    return 32'(m_div);
      3'd6:    return 32'(m_duty);
      3'd7:    return {16'h0, 8'(m_g % 255), 7'h0, m_phase};
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    logic       wr;
    logic [2:0] a;
    logic [9:0] wd;
    @(posedge clk or negedge reset_n);
    if (reset_n !== 1'b1) begin
      m_data = RV; m_mode = '0; m_div = 16'd249; m_duty = 8'hFF;
      m_phase = 1'b1; m_out = RV; m_t = 0; m_g = 0;
    end else begin
      m_out = m_data & (~m_mode | {W{m_phase}}) & {W{(m_g % 255) < int'(m_duty)}};
      m_g++;
      wr = bus.chipselect && !bus.write_n;
      a  = bus.address;
      wd = bus.writedata[9:0];
      if (wr && a == 3'd5) begin
        m_t   = 0;
        m_div = bus.writedata[15:0];
      end else begin
        m_t++;
        if (m_t % ((int'(m_div) + 1) * P) == 0) m_phase = ~m_phase;
      end
      if (wr) begin
        case (a)
          3'd0: m_data = wd;
          3'd1: m_data = m_data | wd;
          3'd2: m_data = m_data & ~wd;
          3'd3: m_data = m_data ^ wd;
          3'd4: m_mode = wd;
          3'd6: m_duty = bus.writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      chk("out_port_model", 32'(out_port), 32'(m_out));
      chk("readdata_model", bus.readdata, m_read(bus.address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk); #2;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #2;
    bus.address = a;
    @(negedge clk);
    chk(nm, bus.readdata, exp);
  endtask

  // negedges until out_port[0] changes, bounded at 40
  task automatic wait_chg0(output int k);
    logic prev;
    prev = out_port[0];
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (out_port[0] === prev && k < 40);
  endtask

  task automatic count_period(output int n_on, output int n_off);
    n_on = 0; n_off = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (out_port === 10'h3FF) n_on++;
      if (out_port === 10'h000) n_off++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int k, n_on, n_off;
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("reset_out_port", 32'(out_port), 32'h155);
    rd_chk(3'd0, 32'h155, "reset_data");
    rd_chk(3'd6, 32'hFF, "reset_duty");
    @(posedge clk); #2 bus.address = 3'd7;
    @(negedge clk);
    chk("reset_phase", bus.readdata & 32'h1, 32'h1);

    // atomic set/clear/toggle
    wr_reg(3'd0, 32'h0F0);
    wr_reg(3'd1, 32'h003);
    wr_reg(3'd2, 32'h010);
    wr_reg(3'd3, 32'hFFFF_F300);
    @(negedge clk);
    chk("out_before_update", 32'(out_port), 32'h0E3);
    @(negedge clk);
    chk("out_after_toggle", 32'(out_port), 32'h3E3);
    rd_chk(3'd0, 32'h3E3, "data_after_sct");
    rd_chk(3'd1, 32'h0, "set_reads0");
    rd_chk(3'd2, 32'h0, "clear_reads0");
    rd_chk(3'd3, 32'h0, "toggle_reads0");

    // blink: phase toggles 8 clocks after BLINK_DIV write, out_port one clock later
    wr_reg(3'd0, 32'h003);
    wr_reg(3'd4, 32'h001);
    wr_reg(3'd5, 32'h1);
    wait_chg0(k); chk("blink_first", 32'(k), 32'd10);
    wait_chg0(k); chk("blink_period1", 32'(k), 32'd8);
    wait_chg0(k); chk("blink_period2", 32'(k), 32'd8);
    chk("steady_channel1", 32'(out_port[1]), 32'h1);

    // PWM
    wr_reg(3'd0, 32'h3FF);
    wr_reg(3'd4, 32'h000);
    wr_reg(3'd6, 32'd64);
    @(posedge clk);
    count_period(n_on, n_off);
    chk("pwm64_on", 32'(n_on), 32'd64);
    chk("pwm64_off", 32'(n_off), 32'd191);
    wr_reg(3'd6, 32'd0);
    @(posedge clk);
    count_period(n_on, n_off);
    chk("pwm0_off", 32'(n_off), 32'd255);
    wr_reg(3'd6, 32'd255);
    @(posedge clk);
    count_period(n_on, n_off);
    chk("pwm255_on", 32'(n_on), 32'd255);

    // BLINK_DIV write on the tick that would toggle phase
    wr_reg(3'd0, 32'h003);
    wr_reg(3'd4, 32'h001);
    wr_reg(3'd5, 32'h1);
    repeat (6) @(posedge clk);
    wr_reg(3'd5, 32'h2);
    wait_chg0(k); chk("collide_first", 32'(k), 32'd14);
    wait_chg0(k); chk("collide_period", 32'(k), 32'd12);

    // asynchronous reset mid-blink, mid-PWM
    wr_reg(3'd6, 32'd10);
    repeat (23) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("areset_out_port", 32'(out_port), 32'h155);
    bus.address = 3'd0; #1 chk("areset_data", bus.readdata, 32'h155);
    bus.address = 3'd4; #1 chk("areset_mode", bus.readdata, 32'h0);
    bus.address = 3'd5; #1 chk("areset_div", bus.readdata, 32'd249);
    bus.address = 3'd6; #1 chk("areset_duty", bus.readdata, 32'hFF);
    bus.address = 3'd7; #1 chk("areset_status", bus.readdata, 32'h1);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
